cby_param_cfg: RTL and testbench

Parametrised Y-channel connection block with an integrated configuration controller. It replaces the fixed per-pin mux memories and address decoder with a word-addressed shadow/active configuration store, adding atomic commit, readback and error flagging. It sits between a vertical routing channel and its left and right grid columns. Configuration is loaded over the programming bus while the fabric keeps running on the previous active settings.

---
 rtl/cby_cfg_pkg.sv | 34 +++
 rtl/cby_ipin_mux.sv | 30 +++
 rtl/cby_param_cfg.sv | 147 ++++++++++++++
 tb/tb_cby_param_cfg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cby_cfg_pkg.sv
// ============================================================================
// Module      : cby_cfg_pkg
// Description : Shared widths, select encoding and track mapping for the
//               Y-channel connection block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cby_cfg_pkg;

    localparam int DEF_CHAN_W   = 9;
    localparam int DEF_NUM_IPIN = 11;
    localparam int DEF_MUX_SIZE = 6;
    localparam int DEF_STRIDE   = 4;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_IPIN);
    localparam int DEF_SEL_W    = $clog2(DEF_MUX_SIZE + 1);

    // Select value 0 leaves the pin undriven (held low); k picks mux input k-1.
    localparam int DISCONNECT = 0;

    typedef struct packed {
        logic                 connected;
        logic [DEF_SEL_W-1:0] input_idx;
    } sel_dec_t;

    // Mux inputs come in bottom/top pairs; each pair shifts STRIDE tracks.
    function automatic int track_of(input int p, input int i,
                                    input int stride, input int chan_w);
        return (p + (i / 2) * stride) % chan_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cby_ipin_mux.sv
// ============================================================================
// Module      : cby_ipin_mux
// Description : Combinational pin selector; select 0 drives the pin low.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cby_ipin_mux
    import cby_cfg_pkg::*;
#(
    parameter int MUX_SIZE = DEF_MUX_SIZE,
    parameter int SEL_W    = DEF_SEL_W
) (
    input  logic [MUX_SIZE-1:0] i_in,
    input  logic [SEL_W-1:0]    i_sel,
    output logic                o_pin
);

    always_comb begin
        o_pin = 1'b0;
        for (int k = 0; k < MUX_SIZE; k++) begin
            if ((i_sel != SEL_W'(DISCONNECT)) && (i_sel == SEL_W'(k + 1))) begin
                o_pin = i_in[k];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cby_param_cfg.sv
// ============================================================================
// Module      : cby_param_cfg
// Description : Y-channel connection block with shadow/active configuration
//               store, atomic commit, readback, ack and sticky error flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cby_param_cfg
    import cby_cfg_pkg::*;
#(
    parameter int CHAN_W   = DEF_CHAN_W,
    parameter int NUM_IPIN = DEF_NUM_IPIN,
    parameter int MUX_SIZE = DEF_MUX_SIZE,
    parameter int STRIDE   = DEF_STRIDE,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int SEL_W    = DEF_SEL_W
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic [CHAN_W-1:0]   chany_bottom_in,
    input  logic [CHAN_W-1:0]   chany_top_in,
    output logic [CHAN_W-1:0]   chany_bottom_out,
    output logic [CHAN_W-1:0]   chany_top_out,
    output logic [NUM_IPIN-1:0] grid_pin,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [SEL_W-1:0]    cfg_wdata,
    input  logic                cfg_commit,
    input  logic [ADDR_W-1:0]   cfg_raddr,
    input  logic                cfg_rsrc,
    output logic [SEL_W-1:0]    cfg_rdata,
    output logic                cfg_ack,
    output logic                cfg_err,
    input  logic                cfg_err_clr
);

    localparam logic [ADDR_W:0] c_num_ipin = (ADDR_W + 1)'(NUM_IPIN);
    localparam logic [SEL_W:0]  c_max_sel  = (SEL_W + 1)'(MUX_SIZE);
    localparam logic [SEL_W-1:0] c_disc    = SEL_W'(DISCONNECT);

    logic [SEL_W-1:0]    shadow_q [NUM_IPIN];
    logic [SEL_W-1:0]    shadow_d [NUM_IPIN];
    logic [SEL_W-1:0]    active_q [NUM_IPIN];
    logic [SEL_W-1:0]    active_d [NUM_IPIN];
    logic [SEL_W-1:0]    rdata_q;
    logic [SEL_W-1:0]    rdata_d;
    logic                ack_q;
    logic                ack_d;
    logic                err_q;
    logic                err_d;

    logic                w_wr_ok;
    logic                w_wr_bad;
    logic [MUX_SIZE-1:0] w_mux_in [NUM_IPIN];

    assign chany_bottom_out = chany_top_in;
    assign chany_top_out    = chany_bottom_in;

    assign w_wr_ok  = cfg_we && ({1'b0, cfg_addr} < c_num_ipin)
                             && ({1'b0, cfg_wdata} <= c_max_sel);
    assign w_wr_bad = cfg_we && !w_wr_ok;

    always_comb begin
        shadow_d = shadow_q;
        for (int p = 0; p < NUM_IPIN; p++) begin
            if (w_wr_ok && (cfg_addr == ADDR_W'(p))) begin
                shadow_d[p] = cfg_wdata;
            end
        end
    end

    // Commit samples the pre-edge shadow, so a same-cycle write waits for the next commit.
    always_comb begin
        active_d = active_q;
        if (cfg_commit) begin
            active_d = shadow_q;
        end
    end

    always_comb begin
        rdata_d = c_disc;
        for (int p = 0; p < NUM_IPIN; p++) begin
            if (cfg_raddr == ADDR_W'(p)) begin
                rdata_d = cfg_rsrc ? active_q[p] : shadow_q[p];
            end
        end
    end

    always_comb begin
        ack_d = w_wr_ok;
        err_d = err_q;
        if (cfg_err_clr) begin
            err_d = 1'b0;
        end
        if (w_wr_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            for (int p = 0; p < NUM_IPIN; p++) begin
                shadow_q[p] <= c_disc;
                active_q[p] <= c_disc;
            end
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign cfg_rdata = rdata_q;
    assign cfg_ack   = ack_q;
    assign cfg_err   = err_q;

    generate
        for (genvar p = 0; p < NUM_IPIN; p++) begin : g_pin
            for (genvar i = 0; i < MUX_SIZE; i++) begin : g_in
                localparam int c_trk = track_of(p, i, STRIDE, CHAN_W);
                if ((i % 2) == 0) begin : g_bot
                    assign w_mux_in[p][i] = chany_bottom_in[c_trk];
                end else begin : g_top
                    assign w_mux_in[p][i] = chany_top_in[c_trk];
                end
            end

            cby_ipin_mux #(
                .MUX_SIZE (MUX_SIZE),
                .SEL_W    (SEL_W)
            ) u_mux (
                .i_in  (w_mux_in[p]),
                .i_sel (active_q[p]),
                .o_pin (grid_pin[p])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cby_param_cfg.sv
// ============================================================================
// Module      : tb_cby_param_cfg
// Description : Table-driven scoreboard bench for cby_param_cfg.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cby_param_cfg;

    logic        prog_clk = 1'b0;
    logic        prog_reset_n;
    logic [8:0]  chany_bottom_in;
    logic [8:0]  chany_top_in;
    logic [8:0]  chany_bottom_out;
    logic [8:0]  chany_top_out;
    logic [10:0] grid_pin;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [2:0]  cfg_wdata;
    logic        cfg_commit;
    logic [3:0]  cfg_raddr;
    logic        cfg_rsrc;
    logic [2:0]  cfg_rdata;
    logic        cfg_ack;
    logic        cfg_err;
    logic        cfg_err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [2:0]  wd;
        logic        commit;
        logic [3:0]  raddr;
        logic        rsrc;
        logic        clr;
        logic        e_ack;
        logic        e_err;
        logic [2:0]  e_rd;
        logic [10:0] e_grid;
    } vec_t;

    typedef struct {
        logic        ack;
        logic        err;
        logic [2:0]  rd;
        logic [10:0] grid;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[16];

    cby_param_cfg dut (
        .prog_clk         (prog_clk),
        .prog_reset_n     (prog_reset_n),
        .chany_bottom_in  (chany_bottom_in),
        .chany_top_in     (chany_top_in),
        .chany_bottom_out (chany_bottom_out),
        .chany_top_out    (chany_top_out),
        .grid_pin         (grid_pin),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_wdata        (cfg_wdata),
        .cfg_commit       (cfg_commit),
        .cfg_raddr        (cfg_raddr),
        .cfg_rsrc         (cfg_rsrc),
        .cfg_rdata        (cfg_rdata),
        .cfg_ack          (cfg_ack),
        .cfg_err          (cfg_err),
        .cfg_err_clr      (cfg_err_clr)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input int addr, input int wd,
                                input logic commit, input int raddr, input logic rsrc,
                                input logic clr, input logic e_ack, input logic e_err,
                                input int e_rd, input logic [10:0] e_grid);
        vec_t v;
        v.we = we;         v.addr = 4'(addr);   v.wd = 3'(wd);
        v.commit = commit; v.raddr = 4'(raddr); v.rsrc = rsrc;
        v.clr = clr;       v.e_ack = e_ack;     v.e_err = e_err;
        v.e_rd = 3'(e_rd); v.e_grid = e_grid;
        return v;
    endfunction

    // Expected pins when pin p holds select (p%6)+1, from the track formula.
    function automatic logic [10:0] grid_model(input logic [8:0] b, input logic [8:0] t);
        logic [10:0] g;
        g = '0;
        for (int p = 0; p < 11; p++) begin
            int i;
            int tr;
            i  = (p % 6);
            tr = (p + (i / 2) * 4) % 9;
            g[p] = (i % 2 == 1) ? t[tr] : b[tr];
        end
        return g;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        cfg_we = v.we; cfg_addr = v.addr; cfg_wdata = v.wd;
        cfg_commit = v.commit; cfg_raddr = v.raddr; cfg_rsrc = v.rsrc;
        cfg_err_clr = v.clr;
        e.ack = v.e_ack; e.err = v.e_err; e.rd = v.e_rd; e.grid = v.e_grid;
        sb_q.push_back(e);
        @(posedge prog_clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_ack"},   32'(cfg_ack),   32'(e.ack));
            chk({tag, "_err"},   32'(cfg_err),   32'(e.err));
            chk({tag, "_rdata"}, 32'(cfg_rdata), 32'(e.rd));
            chk({tag, "_grid"},  32'(grid_pin),  32'(e.grid));
        end
        cfg_we = 1'b0; cfg_commit = 1'b0; cfg_err_clr = 1'b0;
    endtask

    initial begin
        logic [10:0] g_all;

        prog_reset_n = 1'b0;
        chany_bottom_in = '0; chany_top_in = '0;
        cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cfg_commit = 0;
        cfg_raddr = 0; cfg_rsrc = 0; cfg_err_clr = 0;

        tbl[0]  = mk(1, 0, 1, 0,  0, 0, 0, 1, 0, 0, 11'h000);
        tbl[1]  = mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 11'h001);
        tbl[2]  = mk(1, 0, 4, 0,  0, 1, 0, 1, 0, 1, 11'h001);
        tbl[3]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 4, 11'h001);
        tbl[4]  = mk(1, 11, 1, 0, 0, 0, 0, 0, 1, 4, 11'h001);
        tbl[5]  = mk(0, 0, 0, 0,  0, 0, 1, 0, 0, 4, 11'h001);
        tbl[6]  = mk(1, 2, 7, 0,  2, 0, 0, 0, 1, 0, 11'h001);
        tbl[7]  = mk(1, 15, 0, 0, 11, 1, 1, 0, 1, 0, 11'h001);
        tbl[8]  = mk(0, 0, 0, 0,  2, 0, 1, 0, 0, 0, 11'h001);
        tbl[9]  = mk(0, 0, 0, 0,  15, 0, 0, 0, 0, 0, 11'h001);
        tbl[10] = mk(1, 2, 6, 1,  2, 1, 0, 1, 0, 0, 11'h001);
        tbl[11] = mk(0, 0, 0, 1,  2, 1, 0, 0, 0, 0, 11'h005);
        tbl[12] = mk(0, 0, 0, 0,  2, 1, 0, 0, 0, 6, 11'h005);
        tbl[13] = mk(1, 5, 3, 0,  5, 0, 0, 1, 0, 0, 11'h005);
        tbl[14] = mk(1, 6, 2, 0,  5, 0, 0, 1, 0, 3, 11'h005);
        tbl[15] = mk(0, 0, 0, 0,  6, 0, 0, 0, 0, 2, 11'h005);

        repeat (3) @(posedge prog_clk);
        #1;
        chk("rst_rdata", 32'(cfg_rdata), 32'd0);
        chk("rst_ack",   32'(cfg_ack),   32'd0);
        chk("rst_err",   32'(cfg_err),   32'd0);
        chany_bottom_in = 9'h1A5;
        chany_top_in    = 9'h05A;
        #1;
        chk("rst_top_out",    32'(chany_top_out),    32'h1A5);
        chk("rst_bottom_out", 32'(chany_bottom_out), 32'h05A);
        chk("rst_grid",       32'(grid_pin),         32'h000);
        prog_reset_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            apply(tbl[k], $sformatf("tbl%0d", k));
        end

        // Pin 2 follows top_in[1] only.
        chany_top_in = 9'h058;
        #1;
        chk("tog_top1", 32'(grid_pin), 32'h001);
        chany_top_in = 9'h05A;
        chany_bottom_in = 9'h1A7;
        #1;
        chk("tog_bot1", 32'(grid_pin), 32'h005);
        chany_bottom_in = 9'h1A5;
        #1;

        apply(mk(1, 3, 2, 1, 3, 1, 0, 1, 0, 0, 11'h065), "wc_same");
        apply(mk(0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 11'h065), "wc_old");
        apply(mk(0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 11'h06D), "wc_commit2");
        apply(mk(0, 0, 0, 0, 3, 1, 0, 0, 0, 2, 11'h06D), "wc_new");

        for (int p = 0; p < 11; p++) begin
            apply(mk(1, p, (p % 6) + 1, 0, 15, 0, 0, 1, 0, 0, 11'h06D), $sformatf("prog%0d", p));
        end
        g_all = grid_model(9'h1A5, 9'h05A);
        apply(mk(0, 0, 0, 1, 15, 0, 0, 0, 0, 0, g_all), "prog_commit");
        for (int p = 0; p < 11; p++) begin
            apply(mk(0, 0, 0, 0, p, 1, 0, 0, 0, (p % 6) + 1, g_all), $sformatf("prog_rb%0d", p));
        end

        // Write accepted, then reset lands during its ack cycle while another write is driven.
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 3'd5; cfg_raddr = 4'd0; cfg_rsrc = 1'b1;
        @(posedge prog_clk);
        #1;
        chk("mid_ack_before", 32'(cfg_ack), 32'd1);
        cfg_addr = 4'd1;
        #2;
        prog_reset_n = 1'b0;
        #1;
        chk("mid_grid",  32'(grid_pin),  32'h000);
        chk("mid_ack",   32'(cfg_ack),   32'd0);
        chk("mid_rdata", 32'(cfg_rdata), 32'd0);
        chk("mid_err",   32'(cfg_err),   32'd0);
        cfg_we = 1'b0;
        @(posedge prog_clk);
        @(posedge prog_clk);
        #1;
        prog_reset_n = 1'b1;

        for (int p = 0; p < 11; p++) begin
            apply(mk(0, 0, 0, 0, p, 0, 0, 0, 0, 0, 11'h000), $sformatf("post_sh%0d", p));
            apply(mk(0, 0, 0, 0, p, 1, 0, 0, 0, 0, 11'h000), $sformatf("post_act%0d", p));
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
